udxs_sqrt_bcd_disp: RTL and testbench

//  - Downstream stage of the udxs_sqrt engine: consumes an 11-bit square-root result.
//  - Converts it to 4 packed BCD digits with a sequential double-dabble, one shift per clock.
//  - Drives a 4-digit multiplexed 7-segment display from the latched digits.
//  - Sits between the sqrt core's result register and the tile output pins.

---
 rtl/udxs_sqrt_bcd_disp.sv | 171 +++++++++++++++++
 tb/tb_udxs_sqrt_bcd_disp.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/udxs_sqrt_bcd_disp.sv
// ============================================================================
// Module   : udxs_sqrt_bcd_disp
// Purpose  : Converts the 11-bit sqrt result to 4 packed BCD digits with a
//            sequential double-dabble (one shift per clock). Drives a 4-digit
//            multiplexed 7-segment display from the latched digits.
// Options  : UDXS_SQRT_LZ_BLANK_EN - when defined, leading zeros are blanked
//            on the display. The units digit is never blanked.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module udxs_sqrt_bcd_disp #(
  parameter int SCAN_DIV = 10
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [10:0] res_in,
  input  logic        res_valid,
  output logic        busy,
  output logic        overrun,
  output logic [15:0] bcd,
  output logic        bcd_valid,
  output logic [6:0]  seg,
  output logic [3:0]  dig_sel
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CONV = 2'd1;
  localparam logic [1:0] S_LOAD = 2'd2;

  localparam logic [3:0] C_LAST_SHIFT = 4'd10;

  logic [1:0]          state_q,     state_d;
  logic [26:0]         shift_q,     shift_d;
  logic [3:0]          cnt_q,       cnt_d;
  logic [15:0]         bcd_q,       bcd_d;
  logic                bcd_valid_q, bcd_valid_d;
  logic                overrun_q,   overrun_d;
  logic [SCAN_DIV-1:0] scan_q,      scan_d;

  // Shift register with every BCD nibble >= 5 corrected by +3 ahead of the shift
  logic [26:0] adj_shift;

  assign adj_shift[10:0] = shift_q[10:0];

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_adj
      logic [3:0] nib;
      assign nib = shift_q[11 + 4*gi +: 4];
      assign adj_shift[11 + 4*gi +: 4] = (nib >= 4'd5) ? (nib + 4'd3) : nib;
    end
  endgenerate

  // State register plus datapath flops; reset aborts any conversion in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      shift_q     <= '0;
      cnt_q       <= '0;
      bcd_q       <= '0;
      bcd_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
      scan_q      <= '0;
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      cnt_q       <= cnt_d;
      bcd_q       <= bcd_d;
      bcd_valid_q <= bcd_valid_d;
      overrun_q   <= overrun_d;
      scan_q      <= scan_d;
    end
  end

  // Next-state logic: accept in IDLE, 11 shifts in CONV, one LOAD cycle
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (res_valid) state_d = S_CONV;
      S_CONV:  if (cnt_q == C_LAST_SHIFT) state_d = S_LOAD;
      S_LOAD:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath next values; strobes while busy (including LOAD) are only flagged
  always_comb begin
    shift_d     = shift_q;
    cnt_d       = cnt_q;
    bcd_d       = bcd_q;
    bcd_valid_d = 1'b0;
    overrun_d   = overrun_q;
    scan_d      = scan_q + 1'b1;
    case (state_q)
      S_IDLE: begin
        if (res_valid) begin
          shift_d   = {16'h0000, res_in};
          cnt_d     = 4'd0;
          overrun_d = 1'b0;
        end
      end
      S_CONV: begin
        shift_d = adj_shift << 1;
        cnt_d   = cnt_q + 4'd1;
        if (res_valid) overrun_d = 1'b1;
      end
      S_LOAD: begin
        bcd_d       = shift_q[26:11];
        bcd_valid_d = 1'b1;
        if (res_valid) overrun_d = 1'b1;
      end
      default: ;
    endcase
  end

  // 7-segment decode {g,f,e,d,c,b,a}; non-decimal nibbles go dark
  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    case (d)
      4'd0:    seg_decode = 7'h3F;
      4'd1:    seg_decode = 7'h06;
      4'd2:    seg_decode = 7'h5B;
      4'd3:    seg_decode = 7'h4F;
      4'd4:    seg_decode = 7'h66;
      4'd5:    seg_decode = 7'h6D;
      4'd6:    seg_decode = 7'h7D;
      4'd7:    seg_decode = 7'h07;
      4'd8:    seg_decode = 7'h7F;
      4'd9:    seg_decode = 7'h6F;
      default: seg_decode = 7'h00;
    endcase
  endfunction

  logic [1:0] dig_idx;
  logic [3:0] dig_nib;
  logic       dig_blank;

  assign dig_idx = scan_q[SCAN_DIV-1 -: 2];

  // Outputs: busy from state, digit select and segments from registered digits
  always_comb begin
    busy      = (state_q != S_IDLE);
    dig_sel   = 4'b0001 << dig_idx;
    dig_nib   = 4'd0;
    dig_blank = 1'b0;
    case (dig_idx)
      2'd0:    dig_nib = bcd_q[3:0];
      2'd1:    dig_nib = bcd_q[7:4];
      2'd2:    dig_nib = bcd_q[11:8];
      default: dig_nib = bcd_q[15:12];
    endcase
`ifdef UDXS_SQRT_LZ_BLANK_EN
    case (dig_idx)
      2'd1:    dig_blank = (bcd_q[15:4]  == 12'h000);
      2'd2:    dig_blank = (bcd_q[15:8]  == 8'h00);
      2'd3:    dig_blank = (bcd_q[15:12] == 4'h0);
      default: dig_blank = 1'b0;
    endcase
`else
    dig_blank = 1'b0;
`endif
    seg = dig_blank ? 7'h00 : seg_decode(dig_nib);
  end

  assign overrun   = overrun_q;
  assign bcd       = bcd_q;
  assign bcd_valid = bcd_valid_q;

endmodule

`default_nettype wire

// File: tb/tb_udxs_sqrt_bcd_disp.sv
// ============================================================================
// Module   : tb_udxs_sqrt_bcd_disp
// Purpose  : Self-checking bench for udxs_sqrt_bcd_disp (SCAN_DIV=4).
//            Honours UDXS_SQRT_LZ_BLANK_EN for display expectations.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_udxs_sqrt_bcd_disp;

  localparam int SCAN_DIV = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [10:0] res_in = '0;
  logic        res_valid = 1'b0;
  logic        busy;
  logic        overrun;
  logic [15:0] bcd;
  logic        bcd_valid;
  logic [6:0]  seg;
  logic [3:0]  dig_sel;

  int n_checks = 0;
  int n_fail   = 0;

  udxs_sqrt_bcd_disp #(.SCAN_DIV(SCAN_DIV)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .res_in    (res_in),
    .res_valid (res_valid),
    .busy      (busy),
    .overrun   (overrun),
    .bcd       (bcd),
    .bcd_valid (bcd_valid),
    .seg       (seg),
    .dig_sel   (dig_sel)
  );

  always #5 clk = ~clk;

  // Reference scan counter
  logic [SCAN_DIV-1:0] m_scan;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m_scan <= '0;
    else        m_scan <= m_scan + 1'b1;
  end

  typedef struct {
    logic [10:0] val;
    logic [15:0] exp;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] to_bcd(input int v);
    logic [3:0] th, hu, te, un;
    th = 4'(v / 1000);
    hu = 4'((v / 100) % 10);
    te = 4'((v / 10) % 10);
    un = 4'(v % 10);
    return {th, hu, te, un};
  endfunction

  function automatic logic [6:0] seg_of(input logic [3:0] d);
    case (d)
      4'd0: return 7'h3F;  4'd1: return 7'h06;  4'd2: return 7'h5B;
      4'd3: return 7'h4F;  4'd4: return 7'h66;  4'd5: return 7'h6D;
      4'd6: return 7'h7D;  4'd7: return 7'h07;  4'd8: return 7'h7F;
      4'd9: return 7'h6F;  default: return 7'h00;
    endcase
  endfunction

  task automatic strobe(input logic [10:0] v);
    @(negedge clk);
    res_in    = v;
    res_valid = 1'b1;
    @(posedge clk);
    #1;
    res_valid = 1'b0;
  endtask

  task automatic wait_valid(input int maxc, output int lat);
    lat = -1;
    for (int k = 1; k <= maxc; k++) begin
      @(posedge clk);
      #1;
      if (bcd_valid) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic convert(input logic [10:0] v, input string name);
    int lat;
    strobe(v);
    check({name, "_busy"}, busy, 1);
    wait_valid(20, lat);
    check({name, "_lat"}, lat, 12);
    check({name, "_bcd"}, bcd, to_bcd(int'(v)));
  endtask

  task automatic disp_check(input logic [15:0] val, input string name);
    int         idx;
    logic [3:0] d;
    logic [6:0] es;
    for (int c = 0; c < 32; c++) begin
      @(negedge clk);
      idx = int'(m_scan[SCAN_DIV-1 -: 2]);
      d   = val[idx*4 +: 4];
      es  = seg_of(d);
`ifdef UDXS_SQRT_LZ_BLANK_EN
      if (idx != 0 && (val >> (idx*4)) == 16'h0) es = 7'h00;
`endif
      check({name, "_dig_sel"}, dig_sel, 32'(4'b0001 << idx));
      check({name, "_seg"}, seg, es);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int lat;
    int pulses;

    vecs[0] = '{11'd0,    16'h0000};
    vecs[1] = '{11'd9,    16'h0009};
    vecs[2] = '{11'd10,   16'h0010};
    vecs[3] = '{11'd99,   16'h0099};
    vecs[4] = '{11'd100,  16'h0100};
    vecs[5] = '{11'd999,  16'h0999};
    vecs[6] = '{11'd1000, 16'h1000};
    vecs[7] = '{11'd2047, 16'h2047};
    vecs[8] = '{11'd45,   16'h0045};
    vecs[9] = '{11'd1234, 16'h1234};

    // Reset state
    #12;
    check("rst_busy", busy, 0);
    check("rst_overrun", overrun, 0);
    check("rst_bcd", bcd, 16'h0000);
    check("rst_bcd_valid", bcd_valid, 0);
    check("rst_dig_sel", dig_sel, 4'b0001);
    check("rst_seg", seg, 7'h3F);
    @(negedge clk);
    rst_n = 1'b1;

    // 45: busy for 12 cycles, single bcd_valid pulse at N+12
    strobe(11'd45);
    check("b45_busy0", busy, 1);
    for (int k = 1; k <= 11; k++) begin
      @(posedge clk);
      #1;
      check("b45_busy", busy, 1);
      check("b45_early_valid", bcd_valid, 0);
    end
    @(posedge clk);
    #1;
    check("b45_valid", bcd_valid, 1);
    check("b45_busy_fall", busy, 0);
    check("b45_bcd", bcd, 16'h0045);
    @(posedge clk);
    #1;
    check("b45_pulse_end", bcd_valid, 0);

    // Directed table
    for (int i = 0; i < 10; i++) begin
      strobe(vecs[i].val);
      wait_valid(20, lat);
      check("vec_lat", lat, 12);
      check("vec_bcd", bcd, vecs[i].exp);
    end

    // Full sweep against the decimal model
    for (int v = 0; v < 2048; v++) convert(11'(v), "sweep");

    // Strobe of 77 at N+3 during 45: ignored, overrun set
    strobe(11'd45);
    repeat (2) @(posedge clk);
    @(negedge clk);
    res_in    = 11'd77;
    res_valid = 1'b1;
    @(posedge clk);
    #1;
    res_valid = 1'b0;
    res_in    = 11'd1999;
    check("ovr_busy", busy, 1);
    wait_valid(20, lat);
    check("ovr_lat", lat, 9);
    check("ovr_bcd", bcd, 16'h0045);
    check("ovr_flag", overrun, 1);
    strobe(11'd5);
    check("ovr_clear", overrun, 0);
    wait_valid(20, lat);
    check("ovr_next_bcd", bcd, 16'h0005);

    // Strobe on the LOAD edge: not accepted, overrun set
    strobe(11'd12);
    repeat (11) @(posedge clk);
    @(negedge clk);
    res_in    = 11'd99;
    res_valid = 1'b1;
    @(posedge clk);
    #1;
    res_valid = 1'b0;
    check("load_valid", bcd_valid, 1);
    check("load_bcd", bcd, 16'h0012);
    check("load_overrun", overrun, 1);
    check("load_busy", busy, 0);
    @(posedge clk);
    #1;
    check("load_not_accepted", busy, 0);

    // Reset mid-conversion of 1234
    strobe(11'd1234);
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_overrun", overrun, 0);
    check("mid_rst_bcd", bcd, 16'h0000);
    check("mid_rst_bcd_valid", bcd_valid, 0);
    check("mid_rst_dig_sel", dig_sel, 4'b0001);
    check("mid_rst_seg", seg, 7'h3F);
    @(negedge clk);
    @(negedge clk);
    rst_n  = 1'b1;
    pulses = 0;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk);
      #1;
      if (bcd_valid) pulses++;
    end
    check("mid_rst_pulses", pulses, 0);
    check("mid_rst_bcd_hold", bcd, 16'h0000);
    convert(11'd1234, "after_rst");

    // Display scanning and decode
    convert(11'd7, "d7");
    disp_check(16'h0007, "disp7");
    convert(11'd2047, "d2047");
    disp_check(16'h2047, "disp2047");
    convert(11'd1389, "d1389");
    disp_check(16'h1389, "disp1389");
    convert(11'd56, "d56");
    disp_check(16'h0056, "disp56");
    convert(11'd1000, "d1000");
    disp_check(16'h1000, "disp1000");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
